// File: rtl/move_sequencer_if.sv
// move_sequencer_if: groups the solver write port and the stepper front-end
// handshake of move_sequencer. The sequencer takes the slave view; whatever
// feeds moves in and answers move_done takes the master view.
interface move_sequencer_if;
    logic [3:0] move_in;
    logic       move_wr;
    logic [3:0] next_move;
    logic       move_start;
    logic       move_done;

    modport master (
        output move_in,
        output move_wr,
        output move_done,
        input  next_move,
        input  move_start
    );

    modport slave (
        input  move_in,
        input  move_wr,
        input  move_done,
        output next_move,
        output move_start
    );
endinterface

// File: rtl/move_sequencer.sv
// move_sequencer: queues 4-bit face-turn codes in a circular FIFO and hands
// them one at a time to the stepper front end. Each move is issued with a
// one-cycle move_start, followed by the move_done low/high handshake and a
// mechanical settle gap.
// Optional build macro MOVE_CANCEL_EN: adjacent inverse pairs at the queue
// head (codes XOR to 1) are dropped together instead of being issued.
module move_sequencer #(
    parameter int DEPTH         = 64,
    parameter int SETTLE_CYCLES = 1000000,
    parameter int ACK_TIMEOUT   = 16
) (
    input  logic                     clock,
    input  logic                     reset_n,
    move_sequencer_if.slave          bus,
    input  logic                     run,
    input  logic                     abort,
    input  logic                     clear_err,
    output logic                     queue_full,
    output logic                     queue_empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     busy,
    output logic                     seq_done,
    output logic [15:0]              moves_issued,
    output logic                     err_invalid,
    output logic                     err_overflow,
    output logic                     err_timeout
);

    localparam int AW = $clog2(DEPTH);
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0] ACK_LAST    = TW'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_LOW,
        WAIT_HIGH,
        SETTLE,
        FAULT
    } state_t;

    state_t        state, state_next;
    logic [3:0]    mem [DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr, rd_ptr_next;
    logic [3:0]    head;
    logic [3:0]    next_move_q;
    logic          wr_ok;
    logic          cancel_pair;
    logic [1:0]    pop_cnt;
    logic          issue;
    logic          seq_done_next;
    logic          timeout_hit;
    logic          settle_load;
    logic          abort_latched;
    logic [SW-1:0] settle_cnt;
    logic [TW-1:0] ack_cnt;

    assign head        = mem[rd_ptr[AW-1:0]];
    assign count       = wr_ptr - rd_ptr;
    assign queue_full  = (count == (AW+1)'(DEPTH));
    assign queue_empty = (count == '0);
    assign busy        = (state != IDLE);

    // abort takes the write slot, so a write never races the flush
    assign wr_ok = bus.move_wr && !abort && (bus.move_in < 4'd12) && !queue_full;

`ifdef MOVE_CANCEL_EN
    logic [3:0] second;
    assign second      = mem[rd_ptr[AW-1:0] + AW'(1)];
    assign cancel_pair = (state == ISSUE) && (count >= (AW+1)'(2))
                         && ((head ^ second) == 4'd1);
`else
    assign cancel_pair = 1'b0;
`endif

    // a flush moves the read pointer onto the (unchanged) write pointer
    assign rd_ptr_next = abort ? wr_ptr : (rd_ptr + (AW+1)'(pop_cnt));

    assign bus.next_move  = next_move_q;
    assign bus.move_start = (state == ISSUE) && !cancel_pair && !queue_empty;

    // Next-state and per-cycle control decode for the sequencing FSM
    always_comb begin
        state_next    = state;
        pop_cnt       = 2'd0;
        issue         = 1'b0;
        seq_done_next = 1'b0;
        timeout_hit   = 1'b0;
        settle_load   = 1'b0;
        case (state)
            IDLE: begin
                if (run && !abort) begin
                    if (queue_empty) seq_done_next = 1'b1;
                    else             state_next    = ISSUE;
                end
            end
            ISSUE: begin
                if (queue_empty) begin
                    state_next = IDLE;
                end else if (cancel_pair) begin
                    pop_cnt = 2'd2;
                    if (abort || abort_latched) begin
                        state_next = IDLE;
                    end else if (count == (AW+1)'(2)) begin
                        seq_done_next = 1'b1;
                        state_next    = IDLE;
                    end
                end else begin
                    pop_cnt    = 2'd1;
                    issue      = 1'b1;
                    state_next = WAIT_LOW;
                end
            end
            WAIT_LOW: begin
                if (!bus.move_done) begin
                    state_next = WAIT_HIGH;
                end else if (ack_cnt == ACK_LAST) begin
                    timeout_hit = 1'b1;
                    state_next  = FAULT;
                end
            end
            WAIT_HIGH: begin
                if (bus.move_done) begin
                    settle_load = 1'b1;
                    state_next  = SETTLE;
                end
            end
            SETTLE: begin
                if (settle_cnt == '0) begin
                    if (abort || abort_latched) begin
                        state_next = IDLE;
                    end else if (queue_empty) begin
                        seq_done_next = 1'b1;
                        state_next    = IDLE;
                    end else begin
                        state_next = ISSUE;
                    end
                end
            end
            FAULT: begin
                if (clear_err) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // FIFO storage and pointers; abort flushes by catching rd up to wr
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= 4'd0;
        end else begin
            if (wr_ok) begin
                mem[wr_ptr[AW-1:0]] <= bus.move_in;
                wr_ptr              <= wr_ptr + (AW+1)'(1);
            end
            rd_ptr <= rd_ptr_next;
        end
    end

    // Present the upcoming head as soon as ISSUE is entered, held until the next one
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)                 next_move_q <= 4'd0;
        else if (state_next == ISSUE) next_move_q <= mem[rd_ptr_next[AW-1:0]];
    end

    // Acknowledge-timeout and settle-gap counters
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ack_cnt    <= '0;
            settle_cnt <= '0;
        end else begin
            if (state == WAIT_LOW) ack_cnt <= ack_cnt + TW'(1);
            else                   ack_cnt <= '0;
            if (settle_load)
                settle_cnt <= SETTLE_LOAD;
            else if (state == SETTLE && settle_cnt != '0)
                settle_cnt <= settle_cnt - SW'(1);
        end
    end

    // Remember an abort seen mid-move so the sequence stops once the move settles
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)                         abort_latched <= 1'b0;
        else if (state_next == IDLE)          abort_latched <= 1'b0;
        else if (abort && state != IDLE)      abort_latched <= 1'b1;
    end

    // Issue counter and end-of-sequence pulse
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            moves_issued <= 16'd0;
            seq_done     <= 1'b0;
        end else begin
            if (issue) moves_issued <= moves_issued + 16'd1;
            seq_done <= seq_done_next;
        end
    end

    // Sticky error flags; clear_err beats any error raised in the same cycle
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            err_invalid  <= 1'b0;
            err_overflow <= 1'b0;
            err_timeout  <= 1'b0;
        end else if (clear_err) begin
            err_invalid  <= 1'b0;
            err_overflow <= 1'b0;
            err_timeout  <= 1'b0;
        end else begin
            if (bus.move_wr && !abort && bus.move_in >= 4'd12)
                err_invalid <= 1'b1;
            if (bus.move_wr && !abort && bus.move_in < 4'd12 && queue_full)
                err_overflow <= 1'b1;
            if (timeout_hit)
                err_timeout <= 1'b1;
        end
    end

endmodule

// File: tb/tb_move_sequencer.sv
// tb_move_sequencer: directed test of move_sequencer with a small FIFO and a
// short settle gap. A background stepper model answers each move_start with a
// two-clock move_done low pulse and logs every issued move.
module tb_move_sequencer;

    localparam int DEPTH  = 4;
    localparam int SETTLE = 4;
    localparam int ACK    = 16;

    logic        clock;
    logic        reset_n;
    logic        run;
    logic        abort;
    logic        clear_err;
    logic        queue_full;
    logic        queue_empty;
    logic [2:0]  count;
    logic        busy;
    logic        seq_done;
    logic [15:0] moves_issued;
    logic        err_invalid;
    logic        err_overflow;
    logic        err_timeout;

    int check_count = 0;
    int error_count = 0;
    int cyc = 0;
    int seq_done_cnt = 0;
    int low_left = 0;
    bit stepper_en = 1'b1;
    logic [3:0] issued_q[$];
    int         start_cyc[$];

    move_sequencer_if bus ();

    move_sequencer #(
        .DEPTH(DEPTH),
        .SETTLE_CYCLES(SETTLE),
        .ACK_TIMEOUT(ACK)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .bus(bus),
        .run(run),
        .abort(abort),
        .clear_err(clear_err),
        .queue_full(queue_full),
        .queue_empty(queue_empty),
        .count(count),
        .busy(busy),
        .seq_done(seq_done),
        .moves_issued(moves_issued),
        .err_invalid(err_invalid),
        .err_overflow(err_overflow),
        .err_timeout(err_timeout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Stepper model and move logger, sampled 1 ns after each rising edge
    initial begin
        bus.move_done = 1'b1;
        forever begin
            @(posedge clock);
            #1;
            if (low_left > 0) begin
                low_left = low_left - 1;
                if (low_left == 0) bus.move_done = 1'b1;
            end
            if (seq_done) seq_done_cnt = seq_done_cnt + 1;
            if (bus.move_start) begin
                issued_q.push_back(bus.next_move);
                start_cyc.push_back(cyc);
                if (stepper_en) begin
                    bus.move_done = 1'b0;
                    low_left      = 2;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed no end, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        check_count = check_count + 1;
        if (observed !== expected) begin
            error_count = error_count + 1;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs starting at a falling edge, then release them
    task automatic applyStimulus(input logic wr, input logic [3:0] code,
                                 input logic run_i, input logic abort_i,
                                 input logic clear_i);
        bus.move_wr = wr;
        bus.move_in = code;
        run         = run_i;
        abort       = abort_i;
        clear_err   = clear_i;
        @(negedge clock);
        bus.move_wr = 1'b0;
        bus.move_in = 4'd0;
        run         = 1'b0;
        abort       = 1'b0;
        clear_err   = 1'b0;
    endtask

    task automatic writeMove(input logic [3:0] code);
        applyStimulus(1'b1, code, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic waitIdle(input string tag, input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(negedge clock);
            n++;
        end
        checkOutput(tag, busy, 0);
    endtask

    initial begin
        int base;
        int sd_base;
        int n;
        reset_n     = 1'b0;
        run         = 1'b0;
        abort       = 1'b0;
        clear_err   = 1'b0;
        bus.move_wr = 1'b0;
        bus.move_in = 4'd0;
        repeat (3) @(negedge clock);

        // Reset state
        checkOutput("rst_empty", queue_empty, 1);
        checkOutput("rst_count", count, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_start", bus.move_start, 0);
        checkOutput("rst_next_move", bus.next_move, 0);
        checkOutput("rst_issued", moves_issued, 0);
        checkOutput("rst_errs", {err_invalid, err_overflow, err_timeout}, 0);
        reset_n = 1'b1;
        @(negedge clock);

        // Basic sequence 2, 5, 11
        writeMove(4'd2);
        writeMove(4'd5);
        writeMove(4'd11);
        checkOutput("basic_count", count, 3);
        applyStimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        checkOutput("basic_busy", busy, 1);
        waitIdle("basic_idle", 200);
        checkOutput("basic_n", issued_q.size(), 3);
        if (issued_q.size() == 3) begin
            checkOutput("basic_m0", issued_q[0], 2);
            checkOutput("basic_m1", issued_q[1], 5);
            checkOutput("basic_m2", issued_q[2], 11);
            // ISSUE + WAIT_LOW + WAIT_HIGH + SETTLE with move_done already low in WAIT_LOW
            checkOutput("basic_gap0", start_cyc[1] - start_cyc[0], SETTLE + 3);
            checkOutput("basic_gap1", start_cyc[2] - start_cyc[1], SETTLE + 3);
        end
        checkOutput("basic_seq_done", seq_done_cnt, 1);
        checkOutput("basic_issued", moves_issued, 3);
        checkOutput("basic_empty", queue_empty, 1);

        // run on an empty queue only pulses seq_done
        applyStimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        checkOutput("empty_run_done", seq_done_cnt, 2);
        checkOutput("empty_run_busy", busy, 0);

        // Bad writes: invalid code, overflow, clear, then flush in IDLE
        writeMove(4'd12);
        checkOutput("inv_count", count, 0);
        checkOutput("inv_flag", err_invalid, 1);
        writeMove(4'd6);
        writeMove(4'd8);
        writeMove(4'd10);
        writeMove(4'd3);
        writeMove(4'd1);
        checkOutput("ovf_flag", err_overflow, 1);
        checkOutput("ovf_count", count, DEPTH);
        checkOutput("ovf_full", queue_full, 1);
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
        checkOutput("clr_flags", {err_invalid, err_overflow}, 0);
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        checkOutput("idle_abort_count", count, 0);
        checkOutput("idle_abort_busy", busy, 0);

        // Write during ISSUE: pop and push cancel out in count
        base = issued_q.size();
        writeMove(4'd2);
        writeMove(4'd4);
        writeMove(4'd6);
        applyStimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        checkOutput("simul_pre", count, 3);
        writeMove(4'd8);
        checkOutput("simul_count", count, 3);
        waitIdle("simul_idle", 300);
        checkOutput("simul_n", issued_q.size() - base, 4);
        if (issued_q.size() == base + 4) begin
            checkOutput("simul_m3", issued_q[base + 3], 8);
            checkOutput("simul_m0", issued_q[base], 2);
        end
        checkOutput("simul_issued", moves_issued, 7);

        // Timeout: move_done never falls
        stepper_en = 1'b0;
        base = issued_q.size();
        writeMove(4'd5);
        writeMove(4'd7);
        applyStimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        @(negedge clock);
        n = 0;
        while (!err_timeout && n < 40) begin
            @(negedge clock);
            n++;
        end
        checkOutput("to_latency", n, ACK);
        checkOutput("to_flag", err_timeout, 1);
        checkOutput("to_busy", busy, 1);
        checkOutput("to_count", count, 1);
        repeat (10) @(negedge clock);
        checkOutput("to_no_restart", issued_q.size() - base, 1);
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
        checkOutput("to_clear_busy", busy, 0);
        checkOutput("to_clear_flag", err_timeout, 0);
        checkOutput("to_queue_kept", count, 1);
        stepper_en = 1'b1;
        applyStimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        waitIdle("to_drain_idle", 200);
        if (issued_q.size() == base + 2)
            checkOutput("to_drain_move", issued_q[base + 1], 7);
        else
            checkOutput("to_drain_n", issued_q.size() - base, 2);
        checkOutput("to_issued", moves_issued, 9);

        // Abort during WAIT_HIGH of the first move
        base    = issued_q.size();
        sd_base = seq_done_cnt;
        writeMove(4'd1);
        writeMove(4'd3);
        writeMove(4'd5);
        writeMove(4'd7);
        applyStimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        repeat (2) @(negedge clock);
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        checkOutput("abort_count", count, 0);
        checkOutput("abort_busy", busy, 1);
        waitIdle("abort_idle", 100);
        checkOutput("abort_n", issued_q.size() - base, 1);
        checkOutput("abort_no_done", seq_done_cnt - sd_base, 0);
        checkOutput("abort_issued", moves_issued, 10);

        // Inverse-pair cancellation: 0, 1, 4
        base = issued_q.size();
        writeMove(4'd0);
        writeMove(4'd1);
        writeMove(4'd4);
        applyStimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        waitIdle("cancel_idle", 300);
`ifdef MOVE_CANCEL_EN
        checkOutput("cancel_n", issued_q.size() - base, 1);
        if (issued_q.size() == base + 1)
            checkOutput("cancel_move", issued_q[base], 4);
        checkOutput("cancel_issued", moves_issued, 11);
`else
        checkOutput("cancel_n", issued_q.size() - base, 3);
        if (issued_q.size() == base + 3) begin
            checkOutput("cancel_m0", issued_q[base], 0);
            checkOutput("cancel_m2", issued_q[base + 2], 4);
        end
        checkOutput("cancel_issued", moves_issued, 13);
`endif
        checkOutput("cancel_seq_done", seq_done_cnt, 5);

        // Reset asserted mid-move
        writeMove(4'd9);
        writeMove(4'd9);
        applyStimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_count", count, 0);
        checkOutput("midrst_issued", moves_issued, 0);
        @(negedge clock);
        reset_n = 1'b1;
        repeat (4) @(negedge clock);

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
